// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and the fetch-to-decode register
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_inst,
  input  logic                      in_is_branch,
  input  logic [ADDR_WIDTH-1:0]     in_target,
  input  logic                      in_prediction,
  output logic                      in_ready,
  input  logic                      hc_stall,
  input  logic                      hc_flush,
  output logic                      out_valid,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [DATA_WIDTH-1:0]     out_inst,
  output logic                      out_is_branch,
  output logic [ADDR_WIDTH-1:0]     out_target,
  output logic                      out_prediction,
  output logic [$clog2(DEPTH):0]    count,
  output logic [15:0]               flush_events
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * ADDR_WIDTH + DATA_WIDTH + 2;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   flush_events_q, flush_events_d;
  logic          enq, deq;
  assign in_ready     = count_q != CW'(DEPTH);
  assign out_valid    = count_q != '0;
  assign count        = count_q;
  assign flush_events = flush_events_q;
  assign {out_pc, out_inst, out_is_branch, out_target, out_prediction} = out_valid ? mem_q[rd_ptr_q] : '0;
  // Next-state: flush clears everything and beats stall and enqueue
  always_comb begin
    enq            = in_valid & in_ready & ~hc_flush;
    deq            = out_valid & ~hc_stall & ~hc_flush;
    rd_ptr_d       = hc_flush ? '0 : rd_ptr_q + PW'(deq);
    wr_ptr_d       = hc_flush ? '0 : wr_ptr_q + PW'(enq);
    count_d        = hc_flush ? '0 : count_q + CW'(enq) - CW'(deq);
    flush_events_d = (hc_flush && out_valid && flush_events_q != 16'hFFFF) ? flush_events_q + 16'd1 : flush_events_q;
  end
  // Pointer, occupancy and flush-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      flush_events_q <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      flush_events_q <= flush_events_d;
    end
  end
  // Bundle storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {in_pc, in_inst, in_is_branch, in_target, in_prediction};
  end
  // Bookkeeping invariants: occupancy bound, pointer distance, no write while full
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CW'(DEPTH));
      assert (PW'(wr_ptr_q - rd_ptr_q) == PW'(count_q));
      assert (!(in_valid && !in_ready && enq));
    end
  end
endmodule
